// File: rtl/serial_alu.sv
// Bit-serial 64-bit ALU: one SLICE_W slice per cycle, LSB first; out_valid NSLICE cycles after accept.
// One operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module serial_alu #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [2:0]  cntrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0]        a_q, b_q, res_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, zacc_q;
  logic               neg_q, zero_q, ovf_q, cout_q;

  logic [SLICE_W-1:0] a_s, b_s, b_eff, slice_res;
  logic [SLICE_W:0]   sum;
  logic               is_sub, is_arith, last_slice, msb_cin;

  // Operand slice selected by the slice counter
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_s = a_q[k*SLICE_W +: SLICE_W];
        b_s = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  always_comb begin
    is_sub     = (op_q == OP_SUB);
    is_arith   = (op_q == OP_ADD) || is_sub;
    last_slice = (cnt_q == LAST_SLICE);
    b_eff      = is_sub ? ~b_s : b_s;
    sum        = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_q};
    // Carry into the top bit of the slice; only meaningful on the last slice
    msb_cin    = a_s[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum[SLICE_W-1];
    case (op_q)
      OP_PASS:        slice_res = b_s;
      OP_ADD, OP_SUB: slice_res = sum[SLICE_W-1:0];
      OP_AND:         slice_res = a_s & b_s;
      OP_OR:          slice_res = a_s | b_s;
      OP_XOR:         slice_res = a_s ^ b_s;
      default:        slice_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = EXEC;
      EXEC:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= cntrl;
            cnt_q   <= '0;
            zacc_q  <= 1'b0;
            carry_q <= (cntrl == OP_SUB);
          end
        end
        EXEC: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CNT_W'(k)) res_q[k*SLICE_W +: SLICE_W] <= slice_res;
          end
          cnt_q   <= cnt_q + CNT_W'(1);
          carry_q <= sum[SLICE_W];
          zacc_q  <= zacc_q | (|slice_res);
          if (last_slice) begin
            neg_q  <= slice_res[SLICE_W-1];
            zero_q <= ~(zacc_q | (|slice_res));
            cout_q <= is_arith & sum[SLICE_W];
            ovf_q  <= is_arith & (msb_cin ^ sum[SLICE_W]);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = res_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: directed vectors, stall/abort scenarios and a randomized scoreboard run.
module tb_serial_alu;

  localparam int SLICE_W = 16;
  localparam int NSLICE  = 64 / SLICE_W;

  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    res_t        e;
  } vec_t;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] A, B, result;
  logic [2:0]  cntrl;
  logic        negative, zero, overflow, carry_out;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  // Expected flags packed as {n,z,v,c}
  vec_t vecs [13] = '{
    '{64'd254, 64'd1, 3'b010, {64'd255, 4'b0000}},
    '{64'hFFFF_FFFF_FFFF_FF02, 64'd254, 3'b010, {64'd0, 4'b0101}},
    '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010, {64'hFFFF_FFFF_FFFF_FFFE, 4'b1010}},
    '{64'd254, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, {64'd255, 4'b0000}},
    '{64'd0, 64'd0, 3'b011, {64'd0, 4'b0101}},
    '{64'd3, 64'd5, 3'b110, {64'd6, 4'b0000}},
    '{64'd123, 64'h8000_0000_0000_0000, 3'b000, {64'h8000_0000_0000_0000, 4'b1000}},
    '{64'd5, 64'd7, 3'b001, {64'd0, 4'b0100}},
    '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, {64'd0, 4'b0100}},
    '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 3'b100, {64'h00F0_00F0_00F0_00F0, 4'b0000}},
    '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 3'b101, {64'hFFF0_FFF0_FFF0_FFF0, 4'b1000}},
    '{64'h8000_0000_0000_0000, 64'd1, 3'b011, {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}},
    '{64'd1, 64'd2, 3'b011, {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}}
  };

  serial_alu #(.SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    res_t        e;
    logic [64:0] s;
    e = '0;
    s = '0;
    case (op)
      3'b000: e.r = b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[63:0];
        e.c = s[64];
        e.v = (a[63] == b[63]) && (e.r[63] != a[63]);
      end
      3'b011: begin
        s   = {1'b0, a} + {1'b0, ~b} + 65'd1;
        e.r = s[63:0];
        e.c = s[64];
        e.v = (a[63] != b[63]) && (e.r[63] != a[63]);
      end
      3'b100:  e.r = a & b;
      3'b101:  e.r = a | b;
      3'b110:  e.r = a ^ b;
      default: e.r = '0;
    endcase
    e.n = e.r[63];
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic res_t observed();
    return {result, negative, zero, overflow, carry_out};
  endfunction

  // Presents one request at a negedge and scrambles the inputs once it is taken
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait in_ready=%b required 1", in_ready);
    end
    A = a; B = b; cntrl = op; in_valid = 1'b1;
    sb.push_back(model(a, b, op));
    @(negedge clk);
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    cntrl = 3'($urandom);
  endtask

  // Counts edges since acceptance until out_valid shows up
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 68'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h required rdy=1 vld=0 res=0",
               in_ready, out_valid, observed());
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    int   lat;
    res_t got, exp;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_out(lat);
      checks++;
      if (out_valid !== 1'b1 || lat != NSLICE) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d vld=%b required %0d", i, lat, out_valid, NSLICE);
      end
      got = observed();
      checks++;
      if (got !== vecs[i].e) begin
        errors++;
        $display("FAIL dir%0d_value got %h required %h", i, got, vecs[i].e);
      end
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL dir%0d_model got %h required %h", i, got, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_release got rdy=%b vld=%b required rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int   lat;
    res_t snap, exp;
    send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_F0F0_0001, 3'b101);
    wait_out(lat);
    snap = observed();
    exp  = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || snap !== exp) begin
      errors++;
      $display("FAIL stall_value got %h vld=%b required %h", snap, out_valid, exp);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      cntrl = 3'($urandom);
      @(negedge clk);
      checks++;
      if (observed() !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got %h rdy=%b vld=%b required %h rdy=0 vld=1",
                 i, observed(), in_ready, out_valid, snap);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    res_t exp;
    send(64'h1234, 64'd1, 3'b010);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_exec got rdy=%b vld=%b required rdy=0 vld=0", in_ready, out_valid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 68'd0}) begin
      errors++;
      $display("FAIL abort_reset got rdy=%b vld=%b res=%h required rdy=1 vld=0 res=0",
               in_ready, out_valid, observed());
    end
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b1;
    send(64'hDEAD_BEEF, 64'h8000_0000_0000_0000, 3'b000);
    wait_out(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != NSLICE || observed() !== exp || observed() !== {64'h8000_0000_0000_0000, 4'b1000}) begin
      errors++;
      $display("FAIL abort_next got %h lat=%0d required %h lat=%0d", observed(), lat, exp, NSLICE);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   sent = 0, got = 0, cyc = 0, last_acc = 0;
    res_t exp;
    out_ready = 1'b1;
    while (got < 4 && cyc < 200) begin
      in_valid = (sent < 4);
      A = rand_operand();
      B = rand_operand();
      cntrl = 3'($urandom_range(0, 7));
      if (in_valid && in_ready) begin
        sb.push_back(model(A, B, cntrl));
        if (sent > 0) begin
          checks++;
          if (cyc - last_acc != NSLICE + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d required %0d", cyc - last_acc, NSLICE + 2);
          end
        end
        last_acc = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        checks++;
        if (observed() !== exp) begin
          errors++;
          $display("FAIL b2b_value got %h required %h", observed(), exp);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d required 4", got);
    end
  endtask

  task automatic test_random();
    int   sent = 0, got = 0, cyc = 0;
    res_t exp;
    while (got < 200 && cyc < 20000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      A = rand_operand();
      B = rand_operand();
      cntrl = 3'($urandom_range(0, 7));
      if (in_valid && in_ready) begin
        sb.push_back(model(A, B, cntrl));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got %h required no output", observed());
        end else begin
          exp = sb.pop_front();
          if (observed() !== exp) begin
            errors++;
            $display("FAIL rand_value op#%0d got %h required %h", got, observed(), exp);
          end
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 200 || sent != 200 || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_count got %0d sent %0d pending %0d required 200 200 0", got, sent, sb.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    cntrl     = '0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: SLICE_W, default 16, datapath slice width in bits; SHALL be one of 8, 16, 32 or 64; NSLICE = 64/SLICE_W.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 in_valid  input  1  request present on A, B, cntrl.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 A  input  64  first operand.
REQ-007 B  input  64  second operand.
REQ-008 cntrl  input  3  operation code, same encoding as the combinational alu: 000 pass B, 010 add, 011 subtract, 100 AND, 101 OR, 110 XOR.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  64  operation result.
REQ-012 negative, zero, overflow, carry_out  output  1 each  flags, same meaning as the combinational alu.

Function
REQ-013 States: IDLE, EXEC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept: in IDLE with in_valid=1 at a rising edge, register A, B and cntrl, clear the slice counter, clear the zero accumulator, set the carry register (1 for subtract, 0 otherwise), and go to EXEC.
REQ-015 Input changes after acceptance SHALL NOT affect the operation in progress.
REQ-016 EXEC: on each edge, process slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W), LSB slice first, and write it into the result register.
REQ-016a Each slice chains the carry from slice k-1; subtract uses A + ~B + carry.
REQ-017 EXEC lasts exactly NSLICE cycles; after the edge that processes slice NSLICE-1, go to DONE.
REQ-017a Latency: out_valid rises NSLICE edges after the acceptance edge (4 for the default).
REQ-018 zero = 1 iff all 64 result bits are 0; accumulate it across slices.
REQ-018a negative = result[63].
REQ-019 Add/subtract: carry_out = carry out of bit 63; overflow = carry into bit 63 XOR carry out of bit 63.
REQ-019a Subtract carry_out = 1 means no borrow (0-0 gives carry_out=1).
REQ-020 Pass B, AND, OR and XOR SHALL drive overflow = 0 and carry_out = 0.
REQ-021 Undefined cntrl (001, 111): result = 0, zero = 1, negative = 0, overflow = 0, carry_out = 0, with the same latency as a defined operation.
REQ-022 DONE: hold result and all flags stable while out_ready = 0.
REQ-022a In DONE with out_ready = 1 at an edge, go to IDLE; in_ready becomes 1 in the next cycle.
REQ-023 Throughput: one operation per NSLICE+2 cycles at best; no request is accepted while in EXEC or DONE.
REQ-024 Result and flag outputs SHALL be registered; no combinational path from A, B, cntrl or out_ready to any output.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, result=0, negative=0, zero=0, overflow=0, carry_out=0, slice counter=0, carry=0.
REQ-026 Reset asserted in EXEC or DONE aborts the operation with no output handshake; the next request after reset release SHALL be processed correctly.
REQ-027 The first acceptance is possible on the first rising edge after reset returns to 1.

Verification
REQ-028 add, A=254, B=1, out_ready=1 -> out_valid 4 cycles after acceptance; result=255, carry_out=0, overflow=0, negative=0, zero=0.
REQ-029 add, A=-254, B=254 -> result=0, zero=1, carry_out=1, overflow=0.
REQ-029a add, A=B=64'h7FFF_FFFF_FFFF_FFFF -> overflow=1, negative=1, carry_out=0.
REQ-030 subtract, A=254, B=-1 -> result=255, carry_out=0, overflow=0.
REQ-030a subtract, A=0, B=0 -> result=0, carry_out=1, zero=1.
REQ-031 XOR, A=4'b0011, B=4'b0101 -> result=4'b0110, overflow=0, carry_out=0.
REQ-031a Hold out_ready=0 for 10 cycles, then pulse it -> outputs stay stable and in_ready stays 0 throughout; in_ready=1 the cycle after the pulse.
REQ-032 Accept an add, then assert reset during the 2nd EXEC cycle -> all outputs 0 immediately.
REQ-032a After release, a pass-B operation with B=64'h8000_0000_0000_0000 -> result=B, negative=1, zero=0.
REQ-033 200 random A/B/cntrl requests with random out_ready stalls, compared against a reference model -> results and flags match for every operation; no request is lost or duplicated.
